// File: rtl/data_sram_like_responder.sv
// -----------------------------------------------------------------------------
// data_sram_like_responder
//
// Responder end of the data-side SRAM-like interface. The EXE stage sends
// requests, and MEM consumes data_ok/rdata. Each accepted request goes to a
// single-port synchronous SRAM with 1-cycle read latency in the same cycle.
// An in-order response queue tracks outstanding transactions. Each accepted
// request gets exactly one data_ok pulse after a programmable delay.
//
// Parameters:
//   DEPTH   - max outstanding requests (power of two, 2..8)
//   LATENCY - extra cycles between earliest response and data_ok (0..7)
//   AW      - SRAM word-address width; ram_addr = data_addr[AW+1:2]
//
// Ports:
//   clk, resetn              - clock, synchronous active-low reset
//   data_req/wr/size/addr    - request valid, store flag, access size, byte address
//   data_wstrb/wdata         - lane-aligned byte enables and store data
//   data_addr_ok             - request accepted this cycle
//   data_data_ok/data_rdata  - in-order response pulse and load word (0 when idle)
//   ram_en/we/addr/wdata     - SRAM access port
//   ram_rdata                - SRAM read data, valid the cycle after a read
//
// Optional feature (macro DATA_RAND_DELAY_EN):
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   adds 0..3 random cycles to each request's delay. When undefined, the
//   delay is exactly LATENCY.
// -----------------------------------------------------------------------------
module data_sram_like_responder #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [31:0]   data_addr,
    input  logic [3:0]    data_wstrb,
    input  logic [31:0]   data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    // Wide enough for LATENCY (max 7) plus up to 3 random extra cycles.
    localparam int DW = 4;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [DW-1:0] LATENCY_C = DW'(LATENCY);

    // Queue bookkeeping
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count;

    // Per-entry state
    logic          entry_wr     [DEPTH];
    logic [1:0]    entry_size   [DEPTH];
    logic [31:0]   entry_rdata  [DEPTH];
    logic          entry_rvalid [DEPTH];
    logic [DW-1:0] entry_delay  [DEPTH];

    // Capture tracking: the entry accepted last cycle receives ram_rdata now.
    logic          cap_pending;
    logic [PW-1:0] cap_idx;

    // Combinational control
    logic          accept;
    logic          pop;
    logic          head_capture;
    logic          head_ready;
    logic [31:0]   capture_word;
    logic [DW-1:0] delay_load;

`ifdef DATA_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Free-running LFSR. It advances every cycle so the extra delay depends
    // on when a request arrives, not just how many came before it.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign delay_load = LATENCY_C + {2'b00, lfsr[1:0]};
`else
    assign delay_load = LATENCY_C;
`endif

    // Head readiness and pop decision. A head whose read data is arriving
    // this cycle can still pop, so the data is bypassed straight to
    // data_rdata. That is what makes LATENCY=0 respond one cycle after accept.
    always_comb begin
        head_capture = 1'b0;
        head_ready   = 1'b0;
        pop          = 1'b0;
        capture_word = entry_wr[cap_idx] ? 32'h0 : ram_rdata;
        if (cap_pending && (cap_idx == head_ptr)) begin
            head_capture = 1'b1;
        end
        head_ready = entry_rvalid[head_ptr] | head_capture;
        if ((count != '0) && head_ready && (entry_delay[head_ptr] == '0)) begin
            pop = resetn;
        end
    end

    // Acceptance needs only occupancy. A full queue can still accept when
    // the head leaves in the same cycle. Outputs are forced low during reset.
    always_comb begin
        accept = 1'b0;
        if (resetn && data_req && ((count < DEPTH_C) || pop)) begin
            accept = 1'b1;
        end
    end

    assign data_addr_ok = accept;

    // The SRAM is driven straight from the request, so SRAM accesses are
    // issued in exactly the same order as requests are accepted.
    always_comb begin
        ram_en    = accept;
        ram_we    = (accept && data_wr) ? data_wstrb : 4'b0000;
        ram_addr  = data_addr[AW+1:2];
        ram_wdata = data_wdata;
    end

    // Response port: one pulse per pop, rdata held at zero otherwise.
    always_comb begin
        data_data_ok = pop;
        data_rdata   = 32'h0;
        if (pop) begin
            data_rdata = head_capture ? capture_word : entry_rdata[head_ptr];
        end
    end

    // Pointers, occupancy and capture tracking. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_ptr    <= '0;
            tail_ptr    <= '0;
            count       <= '0;
            cap_pending <= 1'b0;
            cap_idx     <= '0;
        end else begin
            cap_pending <= accept;
            if (accept) begin
                cap_idx  <= tail_ptr;
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Per-entry control. Allocation wins over everything else on its slot.
    // Delays count down every cycle whether or not the entry is at the head.
    // This lets younger entries become ready while an older one is stalled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_rvalid[i] <= 1'b0;
                entry_delay[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && (tail_ptr == PW'(i))) begin
                    entry_rvalid[i] <= 1'b0;
                    entry_delay[i]  <= delay_load;
                end else begin
                    if (cap_pending && (cap_idx == PW'(i))) begin
                        entry_rvalid[i] <= 1'b1;
                    end
                    if (entry_delay[i] != '0) begin
                        entry_delay[i] <= entry_delay[i] - DW'(1);
                    end
                end
            end
        end
    end

    // Entry payload. It needs no reset because it is only read through a
    // valid head or a pending capture.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (tail_ptr == PW'(i))) begin
                entry_wr[i]   <= data_wr;
                entry_size[i] <= data_size;
            end else if (cap_pending && (cap_idx == PW'(i))) begin
                entry_rdata[i] <= capture_word;
            end
        end
    end

    // Request fields that are informational only (the byte offset and upper
    // address bits, and the recorded size) are gathered here on purpose.
    logic unused_fields;
    assign unused_fields = ^{data_addr, entry_size[head_ptr]};

endmodule

// File: doc/data_sram_like_responder.md
Name: data_sram_like_responder

Overview:
Responder (slave) end of the data-side SRAM-like interface driven by the CPU's EXE stage (request) and consumed by the MEM stage (data_ok/rdata). It accepts requests with addr_ok and issues them to a single-port synchronous data SRAM with 1-cycle read latency. It tracks outstanding transactions in an in-order response queue and returns exactly one data_ok pulse per accepted request after a programmable delay. It stands in for the cache/AXI bridge in SoC-lite simulation and FPGA bring-up.

Parameters:
DEPTH, 4, max outstanding requests; power of two, 2..8.
LATENCY, 1, extra cycles between earliest possible response and data_ok; 0..7.
AW, 16, SRAM word-address width; ram_addr = data_addr[AW+1:2].

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
data_req  input  1  request valid
data_wr  input  1  1 = store, 0 = load
data_size  input  2  0 = byte, 1 = half, 2 = word; informational, recorded per entry
data_addr  input  32  byte address
data_wstrb  input  4  byte enables, already lane-aligned by requester
data_wdata  input  32  store data, already lane-aligned
data_addr_ok  output  1  request accepted this cycle
data_data_ok  output  1  one-cycle response pulse, in request order
data_rdata  output  32  full load word, valid when data_data_ok is high; 0 otherwise
ram_en  output  1  SRAM access enable
ram_we  output  4  SRAM byte write enables
ram_addr  output  AW  SRAM word address
ram_wdata  output  32  SRAM write data
ram_rdata  input  32  SRAM read data, valid the cycle after ram_en with ram_we == 0

Behaviour:
- Clock clk; reset resetn, synchronous, active-low. On reset: queue empty, count = 0, data_addr_ok = 0 in the reset cycle, data_data_ok = 0, data_rdata = 0, ram_en = 0, ram_we = 0, LFSR = seed.
- Accept: data_addr_ok = data_req & (count < DEPTH | pop_this_cycle). Combinational and independent of data_wr, data_addr and data_wdata.
- On accept at cycle t:
  - SRAM access in the same cycle: ram_en = 1, ram_we = data_wr ? data_wstrb : 4'b0, ram_addr and ram_wdata taken from the request.
  - A queue entry is allocated holding {wr, size, rdata, rdata_valid, delay counter}. The delay counter is loaded with LATENCY.
- SRAM accesses occur strictly in accept order, so read-after-write through this block is always consistent.
- Read capture: at t+1 the entry's rdata takes ram_rdata and rdata_valid is set. Writes set rdata_valid at t+1 with rdata = 0.
- Entry delay counters decrement by 1 per cycle down to 0, starting at t+1, whether or not the entry is at the head.
- Pop: the head is popped when it is valid, rdata_valid (or being captured this cycle), and its counter is 0.
- On pop: data_data_ok = 1 for exactly one cycle. data_rdata = head rdata, or bypassed ram_rdata if capture happens this cycle. Loads and stores both respond.
- Latency: with no contention, data_data_ok arrives at cycle t + 1 + LATENCY. LATENCY = 0 gives data_ok the cycle after addr_ok.
- No backpressure on the response: the requester must sample data_ok. At most one pop per cycle.
- Full: count == DEPTH with no pop means addr_ok = 0 and the SRAM is not accessed. Simultaneous pop and accept when full is allowed; count is unchanged.
- Empty: data_data_ok = 0 and data_rdata = 0.
- Pointers wrap modulo DEPTH. count has width clog2(DEPTH)+1.
- No cancel or flush input. Every accepted request is answered. The requester discards unwanted responses itself.
- Reset mid-operation drops all outstanding entries. No data_ok is issued for them after reset.

Optional Feature:
DATA_RAND_DELAY_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle. On each accept, LFSR[1:0] is added to the entry's counter, giving 0..3 extra cycles per request. Responses remain in order, so a slow head blocks younger entries.
- Undefined: the LFSR is absent and the delay is exactly LATENCY.

Test Plan:
- LATENCY=1: store word 0x1234_5678 to 0x1C000100 (wstrb 4'hF), then load word from the same address -> two data_ok pulses at accept+2; load rdata = 0x1234_5678.
- Byte store 0xAB to 0x1C000102 (wstrb 4'b0100, wdata 0x00AB_0000) over 0x1234_5678 -> next load returns 0x12AB_5678.
- DEPTH=4, LATENCY=7: hold data_req high for 8 cycles -> addr_ok for the first 4 cycles, then low until the first pop; exactly 4 data_ok pulses, in order.
- LATENCY=0: back-to-back loads every cycle -> data_ok every cycle, one cycle after each addr_ok; the queue never fills.
- Reset asserted with 3 requests outstanding -> data_ok never pulses for them; count = 0 and addr_ok reasserts the cycle after reset is released.
- DATA_RAND_DELAY_EN: 16 mixed loads to distinct addresses -> response order matches request order; each delay is within LATENCY+1..LATENCY+4.
